// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters (IDLE/EXEC/RESP), round-robin by default.
// Define ALU_ARB_FIXED_PRIORITY_EN to make requester 0 always win contention.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req0_i,
    input  logic                  Req1_i,
    input  logic [OP_WIDTH-1:0]   Op0_i,
    input  logic [OP_WIDTH-1:0]   Op1_i,
    input  logic [DATA_WIDTH-1:0] A0_i,
    input  logic [DATA_WIDTH-1:0] B0_i,
    input  logic [DATA_WIDTH-1:0] A1_i,
    input  logic [DATA_WIDTH-1:0] B1_i,
    output logic                  Gnt0_o,
    output logic                  Gnt1_o,
    output logic                  Done0_o,
    output logic                  Done1_o,
    output logic [DATA_WIDTH-1:0] Result_o,
    output logic                  Zero_o,
    output logic [OP_WIDTH-1:0]   ALU_Operation_o,
    output logic [DATA_WIDTH-1:0] ALU_A_o,
    output logic [DATA_WIDTH-1:0] ALU_B_o,
    input  logic [DATA_WIDTH-1:0] ALU_Result_i,
    input  logic                  ALU_Zero_i
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  grab, win;
    assign grab = (state_q == IDLE) && (Req0_i || Req1_i);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    assign win = !Req0_i;
`else
    // last_q holds the requester served most recently; contention goes to the other one
    logic last_q, last_d;
    assign win    = (Req0_i && Req1_i) ? !last_q : !Req0_i;
    assign last_d = grab ? win : last_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`endif
    always_comb begin
        state_d = (state_q == IDLE) ? (grab ? EXEC : IDLE) : (state_q == EXEC) ? RESP : IDLE;
        owner_d = grab ? win : owner_q;
        op_d    = grab ? (win ? Op1_i : Op0_i) : op_q;
        a_d     = grab ? (win ? A1_i : A0_i) : a_q;
        b_d     = grab ? (win ? B1_i : B0_i) : b_q;
        res_d   = (state_q == EXEC) ? ALU_Result_i : res_q;
        zero_d  = (state_q == EXEC) ? ALU_Zero_i : zero_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end
    assign Gnt0_o          = (state_q == EXEC) && !owner_q;
    assign Gnt1_o          = (state_q == EXEC) && owner_q;
    assign Done0_o         = (state_q == RESP) && !owner_q;
    assign Done1_o         = (state_q == RESP) && owner_q;
    assign Result_o        = res_q;
    assign Zero_o          = zero_q;
    assign ALU_Operation_o = op_q;
    assign ALU_A_o         = a_q;
    assign ALU_B_o         = b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a transaction-level model of the arbiter.
module tb_alu_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        Req0_i = 1'b0, Req1_i = 1'b0;
    logic [3:0]  Op0_i = '0, Op1_i = '0;
    logic [31:0] A0_i = '0, B0_i = '0, A1_i = '0, B1_i = '0;
    logic        Gnt0_o, Gnt1_o, Done0_o, Done1_o, Zero_o, ALU_Zero_i;
    logic [31:0] Result_o, ALU_A_o, ALU_B_o, ALU_Result_i;
    logic [3:0]  ALU_Operation_o;
    int          n_tests = 0, n_fail = 0;
    logic        pend[2];
    logic [3:0]  pop[2];
    logic [31:0] pa[2], pb[2];
    logic        last, w;
    logic [31:0] m_res, m_a;
    logic        m_zero;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .Req0_i(Req0_i), .Req1_i(Req1_i), .Op0_i(Op0_i), .Op1_i(Op1_i),
        .A0_i(A0_i), .B0_i(B0_i), .A1_i(A1_i), .B1_i(B1_i),
        .Gnt0_o(Gnt0_o), .Gnt1_o(Gnt1_o), .Done0_o(Done0_o), .Done1_o(Done1_o),
        .Result_o(Result_o), .Zero_o(Zero_o),
        .ALU_Operation_o(ALU_Operation_o), .ALU_A_o(ALU_A_o), .ALU_B_o(ALU_B_o),
        .ALU_Result_i(ALU_Result_i), .ALU_Zero_i(ALU_Zero_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return op == 4'd0 ? a + b : op == 4'd1 ? a - b : op == 4'd3 ? (a | b) : 32'd0;
    endfunction

    // the shared ALU sitting outside the arbiter
    always_comb begin
        ALU_Result_i = ref_alu(ALU_Operation_o, ALU_A_o, ALU_B_o);
        ALU_Zero_i   = (ALU_Result_i == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        Req0_i = pend[0]; Op0_i = pop[0]; A0_i = pa[0]; B0_i = pb[0];
        Req1_i = pend[1]; Op1_i = pop[1]; A1_i = pa[1]; B1_i = pb[1];
    endtask

    task automatic model_reset();
        last = 1'b1; m_res = '0; m_zero = 1'b0; m_a = '0;
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        pend[k] = 1'b1; pop[k] = op; pa[k] = a; pb[k] = b;
    endtask

    function automatic logic [3:0] rand_op();
        int s;
        s = $urandom_range(0, 3);
        return s == 0 ? 4'd0 : s == 1 ? 4'd1 : s == 2 ? 4'd3 : 4'($urandom_range(0, 15));
    endfunction

    // one arbitration opportunity: IDLE cycle, then EXEC and RESP if anybody is requesting
    task automatic slot(input bit hold, input bit rnd, output logic wo);
        logic wn;
        drive();
        tick();
        wo = 1'b0;
        if (!pend[0] && !pend[1]) begin
            chk("idle_gnt", {30'd0, Gnt1_o, Gnt0_o}, 32'd0);
            chk("idle_res", Result_o, m_res);
            chk("idle_alu_a", ALU_A_o, m_a);
            return;
        end
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        if (pend[0]) wn = 1'b0;
        else         wn = 1'b1;
`else
        if (pend[0] && pend[1]) wn = (last == 1'b0) ? 1'b1 : 1'b0;
        else if (pend[0])       wn = 1'b0;
        else                    wn = 1'b1;
        last = wn;
`endif
        wo = wn;
        chk("gnt", {30'd0, Gnt1_o, Gnt0_o}, wn ? 32'd2 : 32'd1);
        chk("done_in_exec", {30'd0, Done1_o, Done0_o}, 32'd0);
        chk("alu_op", {28'd0, ALU_Operation_o}, {28'd0, pop[wn]});
        chk("alu_a", ALU_A_o, pa[wn]);
        chk("alu_b", ALU_B_o, pb[wn]);
        m_res = ref_alu(pop[wn], pa[wn], pb[wn]);
        m_zero = (m_res == 32'd0);
        m_a = pa[wn];
        if (!hold) begin
            pend[wn] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            pop[wn] = rand_op(); pa[wn] = $urandom; pb[wn] = $urandom;
        end
        drive();
        tick();
        chk("done", {30'd0, Done1_o, Done0_o}, wn ? 32'd2 : 32'd1);
        chk("gnt_in_resp", {30'd0, Gnt1_o, Gnt0_o}, 32'd0);
        chk("result", Result_o, m_res);
        chk("zero", {31'd0, Zero_o}, {31'd0, m_zero});
        tick();
        chk("back_idle", {28'd0, Gnt1_o, Gnt0_o, Done1_o, Done0_o}, 32'd0);
        chk("res_hold", Result_o, m_res);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin pend[k] = 0; pop[k] = 0; pa[k] = 0; pb[k] = 0; end
        model_reset();
        #12;
        chk("rst_ctrl", {28'd0, Gnt1_o, Gnt0_o, Done1_o, Done0_o}, 32'd0);
        chk("rst_res", Result_o, 32'd0);
        chk("rst_zero", {31'd0, Zero_o}, 32'd0);
        chk("rst_alu", ALU_A_o | ALU_B_o | {28'd0, ALU_Operation_o}, 32'd0);
        tick();
        reset = 1'b0;
        set_req(0, 4'd0, 32'd5, 32'd7);
        slot(0, 0, w);
        chk("add_5_7", Result_o, 32'd12);
        chk("add_zero", {31'd0, Zero_o}, 32'd0);
        set_req(1, 4'd1, 32'd9, 32'd9);
        slot(0, 0, w);
        chk("sub_eq_res", Result_o, 32'd0);
        chk("sub_eq_zero", {31'd0, Zero_o}, 32'd1);
        set_req(0, 4'd7, 32'd1, 32'd1);
        slot(0, 0, w);
        chk("bad_op_res", Result_o, 32'd0);
        chk("bad_op_zero", {31'd0, Zero_o}, 32'd1);
        // both requesters held high straight out of reset
        reset = 1'b1;
        set_req(0, 4'd3, 32'hF0, 32'h0F);
        set_req(1, 4'd1, 32'd3, 32'd5);
        drive();
        tick();
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot(1, 0, w);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            chk("contend_winner", {31'd0, w}, 32'd0);
            chk("contend_res", Result_o, 32'hFF);
`else
            chk("contend_winner", {31'd0, w}, 32'(i % 2));
            chk("contend_res", Result_o, (i % 2) ? 32'hFFFF_FFFE : 32'hFF);
`endif
        end
        pend[0] = 0; pend[1] = 0;
        // reset in the middle of an operation
        set_req(0, 4'd0, 32'd2, 32'd2);
        drive();
        tick();
        chk("mid_gnt", {30'd0, Gnt1_o, Gnt0_o}, 32'd1);
        pend[0] = 0;
        drive();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ctrl", {28'd0, Gnt1_o, Gnt0_o, Done1_o, Done0_o}, 32'd0);
        chk("mid_rst_res", Result_o | ALU_A_o | ALU_B_o | {28'd0, ALU_Operation_o}, 32'd0);
        chk("mid_rst_zero", {31'd0, Zero_o}, 32'd0);
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_done_after_rst", {30'd0, Done1_o, Done0_o}, 32'd0);
        end
        set_req(0, 4'd0, 32'd2, 32'd2);
        slot(0, 0, w);
        chk("post_rst_add", Result_o, 32'd4);
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < 2; k++)
                if (!pend[k] && $urandom_range(0, 2) == 0) set_req(k, rand_op(), $urandom, $urandom);
            slot(0, 1, w);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OP_WIDTH, default 4, ALU operation code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports Req0_i / Req1_i  input  1  request from requester 0 / 1.
REQ-006 SHALL have ports Op0_i / Op1_i  input  OP_WIDTH  requested ALU operation (ADD 0000, SUB 0001, OR 0011).
REQ-007 SHALL have ports A0_i, B0_i / A1_i, B1_i  input  DATA_WIDTH  signed operands per requester.
REQ-008 SHALL have ports Gnt0_o / Gnt1_o  output  1  one-cycle grant pulse; operands captured.
REQ-009 SHALL have ports Done0_o / Done1_o  output  1  one-cycle completion pulse; result valid.
REQ-010 SHALL have port Result_o  output  DATA_WIDTH  registered ALU result.
REQ-011 SHALL have port Zero_o  output  1  registered ALU zero flag.
REQ-012 SHALL have ports ALU_Operation_o, ALU_A_o, ALU_B_o  output  OP_WIDTH/DATA_WIDTH/DATA_WIDTH  registered drive to the shared ALU.
REQ-013 SHALL have ports ALU_Result_i, ALU_Zero_i  input  DATA_WIDTH/1  combinational return from the shared ALU.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC when any Req high, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-015 SHALL, on the edge leaving IDLE, select one requester, load its Op/A/B into ALU_Operation_o/ALU_A_o/ALU_B_o and record the owner.
REQ-016 SHALL assert Gnt of the owner for exactly the EXEC cycle; other Gnt low.
REQ-017 SHALL, on the edge leaving EXEC, load ALU_Result_i into Result_o and ALU_Zero_i into Zero_o.
REQ-018 SHALL assert Done of the owner for exactly the RESP cycle; at most one Done high at any time.
REQ-019 SHALL give latency: Req sampled at edge N -> Gnt high cycle N+1 -> Done high cycle N+2; throughput one op per 3 cycles.
REQ-020 SHALL ignore Req while in EXEC or RESP; requester holds Req and operands stable until Gnt, may change them after Gnt.
REQ-021 SHALL treat Req still high in the RESP cycle as a new request sampled on the RESP->IDLE path only after returning to IDLE (next arbitration at the following edge).
REQ-022 SHALL arbitrate round-robin by default: single request wins; with both requesting, the requester not served last wins; last-served pointer updates on each grant.
REQ-023 SHALL pass unsupported opcodes unchanged to the ALU; resulting Result_o=0, Zero_o=1 completes normally.
REQ-024 SHALL hold Result_o, Zero_o and ALU drive outputs at last values while IDLE.

Reset
REQ-025 SHALL on reset immediately force state IDLE, Gnt0/1_o=0, Done0/1_o=0, Result_o=0, Zero_o=0, ALU_Operation_o=0, ALU_A_o=0, ALU_B_o=0.
REQ-026 SHALL reset last-served pointer to requester 1 so requester 0 wins the first contested arbitration.
REQ-027 SHALL abort an in-flight operation on reset mid-EXEC/RESP with no Done pulse for it.

Configuration
REQ-028 SHALL, when ALU_ARB_FIXED_PRIORITY_EN is defined, replace round-robin with fixed priority: requester 0 always wins contention; pointer logic removed.
REQ-029 SHALL, when ALU_ARB_FIXED_PRIORITY_EN is undefined, use round-robin per REQ-022; all other behaviour identical.

Verification
REQ-030 Req0=1, Op0=0000, A0=5, B0=7 -> Gnt0 at N+1, Done0 at N+2 with Result_o=12, Zero_o=0.
REQ-031 Req1=1, Op1=0001, A1=9, B1=9 -> Done1 with Result_o=0, Zero_o=1; Gnt0/Done0 stay low.
REQ-032 Req0 and Req1 held high continuously from reset (Op0=OR A0=0xF0 B0=0x0F; Op1=SUB A1=3 B1=5) -> grants alternate 0,1,0,1; results 0xFF and 0xFFFFFFFE; with ALU_ARB_FIXED_PRIORITY_EN only requester 0 served.
REQ-033 Req0=1, Op0=0111, A0=1, B0=1 -> Done0 with Result_o=0, Zero_o=1.
REQ-034 Assert reset during EXEC of an ADD 2+2 -> all outputs 0 within the reset, no Done pulse, next Req0 served normally with correct result.
